// File: rtl/dmem_pkg.sv
// Shared definitions for the MEM-stage data responder:
// access formats, MMIO register offsets and error flag indices.
package dmem_pkg;

  localparam logic [2:0] FMT_B  = 3'b000;
  localparam logic [2:0] FMT_H  = 3'b001;
  localparam logic [2:0] FMT_W  = 3'b010;
  localparam logic [2:0] FMT_BU = 3'b100;
  localparam logic [2:0] FMT_HU = 3'b101;

  localparam logic [7:0] OFF_MTIME_LO = 8'h00;
  localparam logic [7:0] OFF_MTIME_HI = 8'h04;
  localparam logic [7:0] OFF_CMP_LO   = 8'h08;
  localparam logic [7:0] OFF_CMP_HI   = 8'h0C;
  localparam logic [7:0] OFF_TX       = 8'h10;
  localparam logic [7:0] OFF_ERR      = 8'h14;

  localparam int ERR_MISALIGN = 0;
  localparam int ERR_UNMAPPED = 1;
  localparam int ERR_MMIO_FMT = 2;
  localparam int ERR_TX_OVF   = 3;
  localparam int ERR_W        = 4;

  typedef enum logic [1:0] {
    SZ_B,
    SZ_H,
    SZ_W
  } size_e;

  function automatic size_e fmt_size(
    input logic [2:0] f
  );
    case (f[1:0])
      2'b00:   return SZ_B;
      2'b01:   return SZ_H;
      default: return SZ_W;
    endcase
  endfunction

  function automatic logic [3:0] byte_en(
    input size_e      sz,
    input logic [1:0] off
  );
    case (sz)
      SZ_B:    return 4'b0001 << off;
      SZ_H:    return off[1] ? 4'b1100 : 4'b0011;
      default: return 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] load_extend(
    input logic [31:0] w,
    input logic [1:0]  off,
    input logic [2:0]  f
  );
    logic [7:0]  b;
    logic [15:0] h;
    b = w[{off, 3'b000} +: 8];
    h = off[1] ? w[31:16] : w[15:0];
    case (fmt_size(f))
      SZ_B:    return f[2] ? {24'b0, b}
                           : {{24{b[7]}}, b};
      SZ_H:    return f[2] ? {16'b0, h}
                           : {{16{h[15]}}, h};
      default: return w;
    endcase
  endfunction

endpackage

// File: rtl/data_mem_responder_tx_fifo.sv
// Byte FIFO feeding the TX port; a push while full
// is accepted only when a pop frees a slot that edge.
import dmem_pkg::*;

module tx_fifo #(
  parameter int DEPTH = 4
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     push,
  input  logic [7:0]               push_data,
  input  logic                     pop,
  output logic [7:0]               pop_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PW = $clog2(DEPTH);

  logic [7:0]    buf_q [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [PW:0]   cnt;
  logic          do_push;
  logic          do_pop;

  assign empty   = (cnt == '0);
  assign full    = (cnt == (PW+1)'(DEPTH));
  assign count   = cnt;
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign pop_data = empty ? 8'h00 : buf_q[rd_ptr];

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      unique case ({do_push, do_pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (do_push) buf_q[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/data_mem_responder.sv
// MEM-stage data port: byte-addressed RAM plus a small
// MMIO window holding mtime/mtimecmp, a TX FIFO and ERR.
import dmem_pkg::*;

module data_mem_responder #(
  parameter int          DEPTH_WORDS = 4096,
  parameter logic [31:0] MMIO_BASE   = 32'hFFFF_FF00,
  parameter int          FIFO_DEPTH  = 4
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] address,
  input  logic [31:0] write_data,
  input  logic        read_enable,
  input  logic        write_enable,
  input  logic [2:0]  format,
  output logic [31:0] read_data,
  output logic        timer_irq,
  output logic        tx_valid,
  output logic [7:0]  tx_data,
  input  logic        tx_ready
);

  localparam int AW = $clog2(DEPTH_WORDS);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic [31:0]      mem [DEPTH_WORDS];
  logic [63:0]      mtime;
  logic [63:0]      mtimecmp;
  logic [ERR_W-1:0] err_q;
  logic [ERR_W-1:0] err_set;
  logic [ERR_W-1:0] err_clr;

  logic        acc, in_ram, in_mmio, mis;
  logic        e_unm, e_fmt, e_mis, ok;
  logic        ram_we, mmio_we, push, pop, full, empty;
  size_e       sz;
  logic [7:0]  off;
  logic [AW-1:0] idx;
  logic [3:0]  be;
  logic [31:0] wlanes, ram_word, mmio_rd;
  logic [CW-1:0] count;

  assign acc     = read_enable | write_enable;
  assign sz      = fmt_size(format);
  assign off     = address[7:0];
  assign idx     = address[AW+1:2];
  assign in_ram  = (address >> (AW + 2)) == 32'd0;
  assign in_mmio = ~in_ram
                 & (address[31:8] == MMIO_BASE[31:8]);

  assign mis = (sz == SZ_H && address[0])
             | (sz == SZ_W && address[1:0] != 2'b00);

  // MMIO format violations take precedence over alignment
  assign e_unm = acc & ~in_ram & ~in_mmio;
  assign e_fmt = acc & in_mmio & (format != FMT_W);
  assign e_mis = acc & ~e_unm & ~e_fmt & mis;
  assign ok    = acc & ~e_unm & ~e_fmt & ~e_mis;

  assign ram_we  = ok & in_ram & write_enable;
  assign mmio_we = ok & in_mmio & write_enable;

  assign be = byte_en(sz, address[1:0]);
  always_comb begin
    wlanes = write_data;
    unique case (sz)
      SZ_B:    wlanes = {4{write_data[7:0]}};
      SZ_H:    wlanes = {2{write_data[15:0]}};
      default: wlanes = write_data;
    endcase
  end

  always_ff @(posedge clock) begin
    if (ram_we) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) mem[idx][8*i +: 8] <= wlanes[8*i +: 8];
      end
    end
  end

  assign ram_word = mem[idx];

  always_comb begin
    mmio_rd = '0;
    unique case (off)
      OFF_MTIME_LO: mmio_rd = mtime[31:0];
      OFF_MTIME_HI: mmio_rd = mtime[63:32];
      OFF_CMP_LO:   mmio_rd = mtimecmp[31:0];
      OFF_CMP_HI:   mmio_rd = mtimecmp[63:32];
      OFF_TX:       mmio_rd = {24'b0, 6'(count), full, empty};
      OFF_ERR:      mmio_rd = {{(32-ERR_W){1'b0}}, err_q};
      default:      mmio_rd = '0;
    endcase
  end

  assign read_data = ~(read_enable & ok) ? 32'h0
                   : in_ram ? load_extend(ram_word, address[1:0], format)
                   : mmio_rd;

  assign push = mmio_we & (off == OFF_TX);
  assign pop  = tx_valid & tx_ready;

  always_comb begin
    err_set = '0;
    err_set[ERR_MISALIGN] = e_mis;
    err_set[ERR_UNMAPPED] = e_unm;
    err_set[ERR_MMIO_FMT] = e_fmt;
    err_set[ERR_TX_OVF]   = push & full & ~pop;
  end

  assign err_clr = (mmio_we && off == OFF_ERR)
                 ? write_data[ERR_W-1:0] : '0;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      mtime    <= '0;
      mtimecmp <= '1;
      err_q    <= '0;
    end else begin
      mtime <= mtime + 64'd1;
      err_q <= (err_q & ~err_clr) | err_set;
      if (mmio_we && off == OFF_CMP_LO)
        mtimecmp[31:0] <= write_data;
      if (mmio_we && off == OFF_CMP_HI)
        mtimecmp[63:32] <= write_data;
    end
  end

  assign timer_irq = (mtime >= mtimecmp);

  tx_fifo #(
    .DEPTH(FIFO_DEPTH)
  ) u_tx_fifo (
    .clock    (clock),
    .reset    (reset),
    .push     (push),
    .push_data(write_data[7:0]),
    .pop      (pop),
    .pop_data (tx_data),
    .full     (full),
    .empty    (empty),
    .count    (count)
  );

  assign tx_valid = ~empty;

endmodule
